// File: rtl/vmem_wr_arbiter_if.sv
// Bundle of the two write requesters, the clear-screen control and the registered vmem write port.
// The slave modport is the arbiter's view of the bundle. The master modport is the view of the requesters and the vmem sink.
// The bundle contains no logic. Handshake timing is set by the arbiter.
interface vmem_wr_arbiter_if #(
  parameter int AW = 19,
  parameter int DW = 24
);
  // keyboard/text requester
  logic          req0_valid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req0_ready;
  // host/pattern requester
  logic          req1_valid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic          req1_ready;
  // clear-screen control
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  // registered vmem write port
  logic          vm_we;
  logic [AW-1:0] vm_waddr;
  logic [DW-1:0] vm_wdata;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    input  clr_start, clr_color,
    output req0_ready, req1_ready,
    output clr_busy, clr_done,
    output vm_we, vm_waddr, vm_wdata
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    output clr_start, clr_color,
    input  req0_ready, req1_ready,
    input  clr_busy, clr_done,
    input  vm_we, vm_waddr, vm_wdata
  );
endinterface

// File: rtl/vmem_wr_arbiter.sv
// Purpose: round-robin arbiter that merges two pixel-write requesters into one registered vmem write port.
//          It has an optional clear-screen sweep, which is built only when VMEM_WR_ARBITER_CLEAR_EN is defined.
// Latency: vm_we rises one cycle after a request is accepted. A clear writes one word per cycle.
// Backpressure: ready is combinational. Ready is low during reset, while a clear runs, and in the cycle that clr_start is sampled.
module vmem_wr_arbiter #(
  parameter int AW        = 19,
  parameter int DW        = 24,
  parameter int CLR_WORDS = 524288
) (
  input logic               clk,
  input logic               resetn,
  vmem_wr_arbiter_if.slave  bus
);

  // Last clear address, truncated to AW bits so that a full 2^AW sweep ends on all-ones.
  localparam logic [AW-1:0] CLR_LAST = AW'(CLR_WORDS - 1);

  // last_q = 1 means requester 1 won the most recent accepted transfer.
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          ready0, ready1;
  logic          arb_en;       // arbitration is allowed this cycle
  logic          clr_wr_vld;   // the clear engine issues a write this cycle
  logic [AW-1:0] clr_wr_addr;
  logic [DW-1:0] clr_wr_dat;

`ifdef VMEM_WR_ARBITER_CLEAR_EN
  typedef enum logic [0:0] {IDLE, CLEAR} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] color_q, color_d;
  logic          done_q, done_d;

  // In the cycle that clr_start is sampled, the clear start takes priority over both requesters.
  assign arb_en      = (state_q == IDLE) && !bus.clr_start;
  assign clr_wr_vld  = (state_q == CLEAR);
  assign clr_wr_addr = cnt_q;
  assign clr_wr_dat  = color_q;

  assign bus.clr_busy = (state_q == CLEAR);
  assign bus.clr_done = done_q;

  // Clear FSM: capture the colour on start, then sweep the counter up to the last word and return to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d = CLEAR;
          color_d = bus.clr_color;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == CLR_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear state registers. A reset aborts a sweep that is in progress, and no clr_done pulse follows.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end
`else
  logic unused_clr;

  assign arb_en      = 1'b1;
  assign clr_wr_vld  = 1'b0;
  assign clr_wr_addr = '0;
  assign clr_wr_dat  = '0;

  assign bus.clr_busy = 1'b0;
  assign bus.clr_done = 1'b0;
  assign unused_clr   = ^{bus.clr_start, bus.clr_color, CLR_LAST};
`endif

  // Round-robin grant. A requester that is valid on its own is granted. On a tie, the requester that did not win last is granted.
  always_comb begin
    ready0 = 1'b0;
    ready1 = 1'b0;
    if (resetn && arb_en) begin
      ready0 = bus.req0_valid && (!bus.req1_valid ||  last_q);
      ready1 = bus.req1_valid && (!bus.req0_valid || !last_q);
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Next write-port contents. The address and data hold their values whenever no write is issued.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    if (clr_wr_vld) begin
      we_d    = 1'b1;
      waddr_d = clr_wr_addr;
      wdata_d = clr_wr_dat;
    end else if (ready0) begin
      we_d    = 1'b1;
      waddr_d = bus.req0_addr;
      wdata_d = bus.req0_data;
      last_d  = 1'b0;
    end else if (ready1) begin
      we_d    = 1'b1;
      waddr_d = bus.req1_addr;
      wdata_d = bus.req1_data;
      last_d  = 1'b1;
    end
  end

  // Registered write port and grant pointer. Reset leaves the pointer on requester 1, so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b1;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
    end
  end

  assign bus.vm_we    = we_q;
  assign bus.vm_waddr = waddr_q;
  assign bus.vm_wdata = wdata_q;

endmodule

// File: doc/vmem_wr_arbiter.md
VMEM_WR_ARBITER -- requirements
Module: vmem_wr_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19, meaning write address width ({h_addr[9:0], v_addr[8:0]}).
REQ-002 SHALL have parameter DW, default 24, meaning pixel data width (RGB 8:8:8).
REQ-003 SHALL have parameter CLR_WORDS, default 524288, meaning number of words swept by a clear, 1..2^AW.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1, meaning reset: synchronous, active-low.
REQ-006 SHALL have ports req0_valid (in, 1), req0_addr (in, AW), req0_data (in, DW) and req0_ready (out, 1), meaning the keyboard/text write requester.
REQ-007 SHALL have ports req1_valid (in, 1), req1_addr (in, AW), req1_data (in, DW) and req1_ready (out, 1), meaning the host/pattern write requester.
REQ-008 SHALL have ports clr_start (in, 1), clr_color (in, DW), clr_busy (out, 1) and clr_done (out, 1), meaning the clear-screen control.
REQ-009 SHALL have ports vm_we (out, 1), vm_waddr (out, AW) and vm_wdata (out, DW), meaning the registered write port to vmem.

Function
REQ-010 SHALL use the states IDLE and CLEAR; in IDLE, requester arbitration is active.
REQ-011 SHALL accept a request when valid&&ready on a clock edge, and SHALL NOT accept one at any other time.
REQ-012 SHALL drive ready combinationally; requester valid, addr and data SHALL be held stable until accepted.
REQ-013 SHALL, in IDLE with only one requester valid, assert that requester's ready.
REQ-014 SHALL, with both valid, grant the requester not granted last (round-robin): exactly one ready high.
REQ-015 SHALL update the last-grant pointer only on an accepted transfer.
REQ-016 SHALL, one cycle after acceptance, assert vm_we=1 for exactly one cycle with the accepted addr/data on vm_waddr/vm_wdata; latency is 1 cycle.
REQ-017 SHALL allow back-to-back acceptance, giving at most one write per cycle at full throughput.
REQ-018 SHALL hold vm_waddr/vm_wdata at their last value while vm_we=0.
REQ-019 SHALL, on clr_start=1 in IDLE, capture clr_color and enter CLEAR on the next edge.
REQ-020 SHALL give clr_start priority over simultaneous requests in that cycle: ready0/ready1=0.
REQ-021 SHALL, in CLEAR, keep clr_busy=1 and ready0/ready1=0.
REQ-022 SHALL, in CLEAR, issue writes to addresses 0..CLR_WORDS-1 in ascending order, one per cycle, with vm_we=1 and vm_wdata set to the captured colour.
REQ-023 SHALL, after the write to address CLR_WORDS-1, return to IDLE and pulse clr_done for one cycle, coincident with clr_busy=0.
REQ-024 SHALL ignore clr_start while in CLEAR; the captured colour SHALL NOT change.
REQ-025 SHALL wrap the clear address counter to 0 on exit, and SHALL NOT overflow into bits above AW.

Reset
REQ-026 SHALL, while resetn=0 at a clock edge, set state=IDLE, vm_we=0, vm_waddr=0, vm_wdata=0, clr_busy=0, clr_done=0, last-grant=requester 1 (so req0 wins the first contention) and the clear counter=0.
REQ-027 SHALL abort a clear or pending write when reset occurs mid-operation: no further vm_we pulses, and no clr_done.
REQ-028 SHALL hold ready0/ready1 at 0 while resetn=0.

Configuration
REQ-029 SHALL include the clear engine (CLEAR state, counter and colour register) when macro VMEM_WR_ARBITER_CLEAR_EN is defined.
REQ-030 SHALL, without VMEM_WR_ARBITER_CLEAR_EN, ignore clr_start and clr_color, tie clr_busy=0 and clr_done=0, and keep only IDLE arbitration (REQ-010..018) behaviourally unchanged.

Verification
REQ-031 SHALL cover: req0 only, addr 0x00123, data 0xFF0000 -> ready0=1 the same cycle; next cycle vm_we=1, vm_waddr=0x00123, vm_wdata=0xFF0000.
REQ-032 SHALL cover: both valid for 4 consecutive cycles out of reset -> grants 0,1,0,1; four vm_we pulses in that order.
REQ-033 SHALL cover: CLR_WORDS=8, clr_start with clr_color=0x00FF00 and req0 valid -> ready0=0; addresses 0..7 written with 0x00FF00 on 8 consecutive cycles; clr_done 1 cycle; then req0 granted.
REQ-034 SHALL cover: clr_start pulsed again at clear address 3 with colour 0x0000FF -> ignored; all 8 words written 0x00FF00.
REQ-035 SHALL cover: resetn=0 at clear address 4 -> vm_we=0 and clr_busy=0 next cycle; no clr_done.
REQ-036 SHALL cover: macro undefined, clr_start=1 -> clr_busy and clr_done stay 0; requests are granted normally.
